// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-word adder that reuses one 32-bit CLA slice, one word per cycle

// Parallel-prefix carry-lookahead adder for one 32-bit word.
module cla_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic [31:0] g [6];
    logic [31:0] p [6];
    logic [32:0] c;

    // Kogge-Stone prefix: level l combines spans 2^l apart; g[5][i]/p[5][i] cover bits i..0
    always_comb begin
        g[0] = a & b;
        p[0] = a ^ b;
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 32; i++) begin
                g[l+1][i] = (i >= (1 << l)) ? g[l][i] | (p[l][i] & g[l][i-(1<<l)]) : g[l][i];
                p[l+1][i] = (i >= (1 << l)) ? p[l][i] & p[l][i-(1<<l)] : p[l][i];
            end
        end
        c[0] = ci;
        for (int i = 0; i < 32; i++) c[i+1] = g[5][i] | (p[5][i] & ci);
        s  = p[0] ^ c[31:0];
        co = c[32];
    end
endmodule

module wide_add_seq #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   ci,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] s,
    output logic                   co,
    output logic                   ovf
);
    localparam int N  = WIDTH * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     a_q, b_q, cat;
    logic [N-WIDTH-1:0] acc;
    logic             carry, last, slice_co;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] slice_s;

    // Operands shift right each RUN cycle so the slice always sees the current word at bit 0
    cla_32bits u_cla (
        .a  (a_q[WIDTH-1:0]),
        .b  (b_q[WIDTH-1:0]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    assign last = idx == IW'(WORDS - 1);
    assign cat  = {slice_s, acc};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs; in_ready is gated by rst_n so it reads 0 during reset
    always_comb begin
        state_nxt = state;
        in_ready  = rst_n && state == IDLE;
        out_valid = state == DONE;
        state_nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
                    state == RUN  ? (last ? DONE : RUN) :
                                    (out_ready ? IDLE : DONE);
    end

    // Datapath: latch on accept, add one word per RUN cycle, publish result on the last word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            s     <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= ci;
            idx   <= '0;
        end else if (state == RUN) begin
            a_q   <= a_q >> WIDTH;
            b_q   <= b_q >> WIDTH;
            acc   <= cat[N-1:WIDTH];
            carry <= slice_co;
            idx   <= last ? idx : idx + 1'b1;
            if (last) begin
                s   <= cat;
                co  <= slice_co;
                ovf <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[WIDTH-1] != a_q[WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: randomized self-checking bench for wide_add_seq against an arithmetic model
module tb_wide_add_seq;
    localparam int WIDTH = 32;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         ci = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] s;
    logic         co;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    wide_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N:0] got, input logic [N:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] rnd();
        logic [N-1:0] r;
        int sel = $urandom_range(0, 7);
        for (int w = 0; w < WORDS; w++) r[w*WIDTH +: WIDTH] = $urandom;
        return sel == 0 ? {N{1'b1}} : sel == 1 ? '0 : r;
    endfunction

    // Reference: plain (N+1)-bit addition plus the sign-bit overflow rule
    task automatic model(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tci,
                         output logic [N-1:0] es, output logic eco, output logic eovf);
        logic [N:0] full;
        full = {1'b0, ta} + {1'b0, tb} + {{N{1'b0}}, tci};
        es   = full[N-1:0];
        eco  = full[N];
        eovf = (ta[N-1] == tb[N-1]) && (es[N-1] != ta[N-1]);
    endtask

    task automatic run(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tci, input int hold);
        logic [N-1:0] es;
        logic         eco, eovf;
        int           n, lat;
        model(ta, tb, tci, es, eco, eovf);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready", in_ready, 1);
        a = ta; b = tb; ci = tci; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; a = rnd(); b = rnd(); ci = 1'($urandom);
        chk("busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, WORDS);
        chk("sum", s, es);
        chk("co", co, eco);
        chk("ovf", ovf, eovf);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom); a = rnd(); b = rnd(); ci = 1'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            chk("hold_sum", s, es);
            chk("hold_co_ovf", {co, ovf}, {eco, eovf});
        end
        out_ready = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("release_valid", out_valid, 0);
        chk("release_idle", in_ready, 1);
        chk("idle_sum", s, es);
        chk("idle_co_ovf", {co, ovf}, {eco, eovf});
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] es, ta, tb;
        logic         eco, eovf;
        int           pulses;
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", s, 0);
        chk("rst_co_ovf", {co, ovf}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        run({N{1'b1}}, '0, 1'b1, 0);
        run({1'b0, {N-1{1'b1}}}, 1, 1'b0, 2);
        run({1'b1, {N-1{1'b0}}}, {1'b1, {N-1{1'b0}}}, 1'b0, 1);
        run({32'h0, {96{1'b1}}}, 1, 1'b0, 10);

        // Back-to-back throughput with out_ready held high
        ta = rnd(); tb = rnd();
        model(ta, tb, 1'b1, es, eco, eovf);
        a = ta; b = tb; ci = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                chk("tput_sum", {co, s}, {eco, es});
            end
        end
        chk("tput_count", pulses, 10);
        in_valid = 1'b0; out_ready = 1'b0;

        // Abort during the second RUN cycle
        a = rnd(); b = rnd(); ci = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_sum", s, 0);
        chk("abort_co_ovf", {co, ovf}, 0);
        chk("abort_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_result", out_valid, 0);
        end
        run(5, 7, 1'b1, 0);

        for (int k = 0; k < 300; k++) run(rnd(), rnd(), 1'($urandom), $urandom_range(0, 3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
